alu_execute_stage: RTL and testbench

Integer execute stage of the single-cycle MIPS-style datapath. Combines three functions: the ALU control decoder (funct + ALUOp → 4-bit operation selector), the 32-bit ALU with zero and overflow flags, and the 8-bit PC+4 incrementer that feeds the PC mux. ALU result and flags are registered; the selector and the PC increment are combinational.

---
 rtl/alu_execute_stage.sv | 184 ++++++++++++++++++
 tb/tb_alu_execute_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_execute_stage
//
// Integer execute stage of a single-cycle MIPS-style datapath. It has three
// parts:
//   * ALU control decoder: turns funct and ALUOp into a 4-bit selector.
//   * 32-bit ALU: its result, zero flag and signed-overflow flag are
//     registered.
//   * 8-bit PC+4 incrementer that feeds the PC mux.
// The selector and the PC increment are combinational. The result and both
// flags have one clock of latency.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   en         in   1   load enable for the result and flag registers
//   func       in   6   instruction funct field
//   alu_op     in   3   ALUOp from the control unit
//   operador1  in  32   operand A
//   operador2  in  32   operand B
//   pc_in      in   8   current PC
//   out_op     out  4   decoded ALU selector (combinational)
//   pc_plus4   out  8   pc_in + 4, wraps modulo 256 (combinational)
//   resultado  out 32   registered ALU result
//   zf         out  1   registered zero flag
//   ovf        out  1   registered signed-overflow flag
// ---------------------------------------------------------------------------
module alu_execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [5:0]  func,
  input  logic [2:0]  alu_op,
  input  logic [31:0] operador1,
  input  logic [31:0] operador2,
  input  logic [7:0]  pc_in,
  output logic [3:0]  out_op,
  output logic [7:0]  pc_plus4,
  output logic [31:0] resultado,
  output logic        zf,
  output logic        ovf
);

  // ALUOp encodings from the control unit
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  // R-type funct field encodings
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU selector codes
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_XOR = 4'b0011;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;
  localparam logic [3:0] SEL_NOP = 4'b1111;

  logic [3:0]  w_sel;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  logic        w_lt;
  logic [31:0] w_result;
  logic        w_ovf;
  logic        w_zero;

  logic [31:0] r_result;
  logic        r_zf;
  logic        r_ovf;

  // -------------------------------------------------------------------------
  // ALU control decoder
  // -------------------------------------------------------------------------
  // NOTE: each always_comb assigns its outputs a default before the case.
  // Every path then drives every output, so no latch is inferred.
  always_comb begin
    w_sel = SEL_ADD;
    case (alu_op)
      ALUOP_ADD: w_sel = SEL_ADD;
      ALUOP_SUB: w_sel = SEL_SUB;
      ALUOP_AND: w_sel = SEL_AND;
      ALUOP_OR:  w_sel = SEL_OR;
      ALUOP_SLT: w_sel = SEL_SLT;
      ALUOP_RTYPE: begin
        case (func)
          FUNCT_ADD: w_sel = SEL_ADD;
          FUNCT_SUB: w_sel = SEL_SUB;
          FUNCT_AND: w_sel = SEL_AND;
          FUNCT_OR:  w_sel = SEL_OR;
          FUNCT_XOR: w_sel = SEL_XOR;
          FUNCT_NOR: w_sel = SEL_NOR;
          FUNCT_SLT: w_sel = SEL_SLT;
          default:   w_sel = SEL_NOP;
        endcase
      end
      // 110 and 111 are unused by the control unit and fall back to ADD.
      default:   w_sel = SEL_ADD;
    endcase
  end

  assign out_op = w_sel;

  // -------------------------------------------------------------------------
  // ALU datapath
  // -------------------------------------------------------------------------
  assign w_sum  = operador1 + operador2;
  assign w_diff = operador1 - operador2;

  // Signed overflow, judged only from sign bits.
  // ADD overflows when both operands share a sign and the sum's sign differs.
  // SUB overflows when the operands differ in sign and the difference's sign
  // differs from the minuend.
  assign w_add_ovf = (operador1[31] == operador2[31]) && (w_sum[31]  != operador1[31]);
  assign w_sub_ovf = (operador1[31] != operador2[31]) && (w_diff[31] != operador1[31]);

  assign w_lt = $signed(operador1) < $signed(operador2);

  always_comb begin
    w_result = 32'd0;
    w_ovf    = 1'b0;
    case (w_sel)
      SEL_AND: w_result = operador1 & operador2;
      SEL_OR:  w_result = operador1 | operador2;
      SEL_XOR: w_result = operador1 ^ operador2;
      SEL_NOR: w_result = ~(operador1 | operador2);
      SEL_ADD: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      SEL_SUB: begin
        w_result = w_diff;
        w_ovf    = w_sub_ovf;
      end
      SEL_SLT: w_result = {31'd0, w_lt};
      default: w_result = 32'd0;  // NOP and any code the decoder never emits
    endcase
  end

  // The zero flag comes from the same value that is loaded, so the result
  // and its flag can never disagree.
  assign w_zero = (w_result == 32'd0);

  // -------------------------------------------------------------------------
  // Result and flag registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples its pre-edge inputs, with no ordering race between blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= 32'd0;
      r_zf     <= 1'b1;  // the reset result is zero, so the zero flag is set
      r_ovf    <= 1'b0;
    end else if (en) begin
      r_result <= w_result;
      r_zf     <= w_zero;
      r_ovf    <= w_ovf;
    end
  end

  assign resultado = r_result;
  assign zf        = r_zf;
  assign ovf       = r_ovf;

  // -------------------------------------------------------------------------
  // PC incrementer: 8-bit add that wraps, with no carry out
  // -------------------------------------------------------------------------
  assign pc_plus4 = pc_in + 8'd4;

endmodule

// File: tb/tb_alu_execute_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_execute_stage
//
// Self-checking bench for alu_execute_stage. A behavioural model computes the
// expected outputs with plain arithmetic. A compare process checks the DUT
// against that model on every falling clock edge. Directed checks with
// hand-computed literals pin the model itself.
// ---------------------------------------------------------------------------
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [5:0]  func;
  logic [2:0]  alu_op;
  logic [31:0] operador1;
  logic [31:0] operador2;
  logic [7:0]  pc_in;
  logic [3:0]  out_op;
  logic [7:0]  pc_plus4;
  logic [31:0] resultado;
  logic        zf;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  alu_execute_stage dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .func      (func),
    .alu_op    (alu_op),
    .operador1 (operador1),
    .operador2 (operador2),
    .pc_in     (pc_in),
    .out_op    (out_op),
    .pc_plus4  (pc_plus4),
    .resultado (resultado),
    .zf        (zf),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] model_sel(input logic [2:0] op, input logic [5:0] f);
    logic [3:0] s;
    case (op)
      3'b001: s = 4'b0110;
      3'b011: s = 4'b0000;
      3'b100: s = 4'b0001;
      3'b101: s = 4'b0111;
      3'b010: begin
        case (f)
          6'b100000: s = 4'b0010;
          6'b100010: s = 4'b0110;
          6'b100100: s = 4'b0000;
          6'b100101: s = 4'b0001;
          6'b100110: s = 4'b0011;
          6'b100111: s = 4'b1100;
          6'b101010: s = 4'b0111;
          default:   s = 4'b1111;
        endcase
      end
      default: s = 4'b0010;
    endcase
    return s;
  endfunction

  // Produces {ovf, result}. Overflow is decided by whether the true signed
  // value leaves the 32-bit range, computed in 64-bit arithmetic.
  function automatic logic [32:0] model_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, t;
    logic [31:0] r;
    logic        o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0;
    o = 1'b0;
    case (s)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        t = sa + sb;
        r = 32'(t);
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'b0110: begin
        t = sa - sb;
        r = 32'(t);
        o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {o, r};
  endfunction

  logic [31:0] m_result;
  logic        m_zf;
  logic        m_ovf;

  always @(posedge clk or negedge reset) begin
    logic [32:0] v;
    if (!reset) begin
      m_result <= 32'd0;
      m_zf     <= 1'b1;
      m_ovf    <= 1'b0;
    end else if (en) begin
      v = model_alu(model_sel(alu_op, func), operador1, operador2);
      m_result <= v[31:0];
      m_zf     <= (v[31:0] == 32'd0);
      m_ovf    <= v[32];
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp_out_op",   {28'd0, out_op},   {28'd0, model_sel(alu_op, func)});
      check("cmp_pc_plus4", {24'd0, pc_plus4}, 32'((int'(pc_in) + 4) % 256));
      check("cmp_result",   resultado,         m_result);
      check("cmp_zf",       {31'd0, zf},       {31'd0, m_zf});
      check("cmp_ovf",      {31'd0, ovf},      {31'd0, m_ovf});
    end
  end

  // Drives inputs just after a rising edge, then advances one clock.
  task automatic step(input logic [2:0] op, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b);
    alu_op    = op;
    func      = f;
    operador1 = a;
    operador2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string name, input logic [31:0] r, input logic z, input logic o);
    check({name, "_result"}, resultado,    r);
    check({name, "_zf"},     {31'd0, zf},  {31'd0, z});
    check({name, "_ovf"},    {31'd0, ovf}, {31'd0, o});
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] functs [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b100110, 6'b100111, 6'b101010, 6'b000000};
  logic [3:0] sels   [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                             4'b0011, 4'b1100, 4'b0111, 4'b1111};

  initial begin
    reset = 1'b0; en = 1'b0; func = 6'd0; alu_op = 3'd0;
    operador1 = 32'd0; operador2 = 32'd0; pc_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset_state", 32'd0, 1'b1, 1'b0);
    cmp_on = 1'b1;

    // Release reset; first load on the next edge.
    reset = 1'b1;
    en    = 1'b1;
    step(3'b000, 6'd0, 32'd5, 32'd7);
    check_regs("add_5_7", 32'd12, 1'b0, 1'b0);

    // R-type decode sweep
    for (int i = 0; i < 8; i++) begin
      alu_op = 3'b010;
      func   = functs[i];
      operador1 = $urandom;
      operador2 = $urandom;
      #1;
      check($sformatf("rtype_sel_%0d", i), {28'd0, out_op}, {28'd0, sels[i]});
      @(posedge clk);
      #1;
    end

    // Arithmetic and flags
    step(3'b001, 6'd0, 32'h0000_1234, 32'h0000_1234);
    check_regs("sub_equal", 32'd0, 1'b1, 1'b0);
    step(3'b000, 6'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    check_regs("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    step(3'b001, 6'd0, 32'h8000_0000, 32'h0000_0001);
    check_regs("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Signed SLT
    step(3'b101, 6'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    check_regs("slt_neg_lt", 32'd1, 1'b0, 1'b0);
    step(3'b101, 6'd0, 32'h0000_0001, 32'hFFFF_FFFF);
    check_regs("slt_pos_ge", 32'd0, 1'b1, 1'b0);

    // Logic through the R-type path
    step(3'b010, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_regs("and", 32'h00F0_00F0, 1'b0, 1'b0);
    step(3'b010, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_regs("or", 32'hFFF0_FFF0, 1'b0, 1'b0);
    step(3'b010, 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_regs("xor", 32'hFF00_FF00, 1'b0, 1'b0);
    step(3'b010, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_regs("nor", 32'h000F_000F, 1'b0, 1'b0);

    // PC incrementer, including the wrap
    pc_in = 8'd0;
    #1;
    check("pc_0", {24'd0, pc_plus4}, 32'd4);
    pc_in = 8'd252;
    #1;
    check("pc_252_wrap", {24'd0, pc_plus4}, 32'd0);
    @(posedge clk);
    #1;

    // Enable low: registers hold over three edges
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 6'd0, 32'h0000_0001, 32'h8000_0000 + i);
      check_regs($sformatf("hold_%0d", i), 32'h000F_000F, 1'b0, 1'b0);
    end

    // Mid-run asynchronous reset, checked before any clock edge
    en = 1'b1;
    step(3'b000, 6'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check_regs("pre_reset", 32'hFFFF_FFFE, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_regs("async_reset", 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_regs("reset_held", 32'd0, 1'b1, 1'b0);
    reset = 1'b1;

    // Reset asserted in the same instant as a load edge
    operador1 = 32'd9; operador2 = 32'd9; alu_op = 3'b000;
    @(posedge clk);
    reset = 1'b0;
    #1;
    check_regs("reset_wins", 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized phase, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(5, 0))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        default: ;
      endcase
      en    = ($urandom_range(9, 0) < 8);
      pc_in = 8'($urandom);
      if ($urandom_range(40, 0) == 0) reset = 1'b0;
      else reset = 1'b1;
      step(3'($urandom), ($urandom_range(1, 0) == 1) ? functs[$urandom_range(7, 0)] : 6'($urandom), a, b);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
